hilo_div: RTL and testbench
===========================

# hilo_div

Iterative 32-bit radix-2 restoring divider that executes MIPS DIV/DIVU for the pipelined core's execute stage and produces the {HI, LO} pair consumed by the HI/LO register write path. The controller's decode issues a divide. This block answers with a multi-cycle busy/ready handshake. The hazard unit uses `busy` to stall the front of the pipeline. The write-back path captures `result` on the `ready` pulse.

## Interface
- No parameters; width fixed at 32.
- `clk  in  1`  system clock, all state updates on rising edge.
- `rst  in  1`  asynchronous, active-low reset.
- `start  in  1`  request to begin a divide; sampled only in IDLE.
- `signed_div  in  1`  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `a  in  32`  dividend; sampled with `start`.
- `b  in  32`  divisor; sampled with `start`.
- `annul  in  1`  synchronous cancel of the in-flight divide (pipeline flush).
- `busy  out  1`  stall request to the hazard unit.
- `ready  out  1`  single-cycle result-valid pulse.
- `result  out  64`  {HI = remainder, LO = quotient}.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN when `start`=1.
  - Latch |a|, |b|, `signed_div`, sign(a), sign(b).
  - 6-bit counter cleared to 0.
- RUN: one restoring step per cycle.
  - Shift the 64-bit {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem[63:32] using a 33-bit subtraction.
  - If the subtraction is non-negative, keep the difference and set quo bit 0.
  - The counter increments. After step 31 (counter = 31), go to DONE.
- RUN -> IDLE when `annul`=1. `annul` has priority over the step. No `ready`; `result` unchanged.
- DONE: drive `ready`=1 for exactly one cycle, then go to IDLE.
- Sign correction, applied only when `signed_div`=1:
  - The quotient is negated if sign(a) XOR sign(b).
  - The remainder is negated if sign(a).
  - The corrected value is registered into `result` on the RUN->DONE edge.
- Divide by zero (b = 0) still takes the full latency. It forces LO = 32'hFFFFFFFF and HI = a (raw operand), for both signed and unsigned.
- Signed overflow: 32'h80000000 / 32'hFFFFFFFF gives LO = 32'h80000000, HI = 0.
- `start` in RUN or DONE is ignored. There is no queueing.
- `annul` in IDLE or DONE has no effect.
- `result` holds its last value until the next completed divide. It does not change on `start` or on `annul`.

## Timing
- Reset values: state IDLE, `busy`=0, `ready`=0, `result`=64'h0, counter 0.
- Reset asserted mid-RUN aborts immediately to the reset values.
- `busy` = (IDLE & `start`) | RUN. This is combinational so the stall takes effect in the issue cycle.
- `busy` is 0 in DONE.
- Latency: `start` in cycle T; RUN in T+1..T+32; `ready`=1 and `result` valid in T+33.
- Next `start` is accepted at T+34 at the earliest.
- `annul` sampled in cycle N of RUN puts the block in IDLE with `busy`=0 in N+1.

## Configuration
- `HILO_DIV_EARLY_OUT_EN` defined: in IDLE with `start`, if |a| < |b| and b != 0, the block skips RUN.
  - It goes IDLE -> DONE directly with LO = 0 and HI = a (signed or unsigned).
  - `ready` arrives at T+1.
  - `busy`=1 in cycle T only.
- Not defined: every divide takes the fixed 33-cycle latency.

## Test plan
- Unsigned: `start`, `signed_div`=0, a=100, b=7 at T -> `busy`=1 T..T+32; `ready` at T+33 with `result` = {32'd2, 32'd14}.
- Signed: a=32'hFFFFFFF9 (-7), b=2 -> `ready` at T+33 with `result` = {32'hFFFFFFFF, 32'hFFFFFFFD}.
- Divide by zero: a=32'h12345678, b=0, unsigned -> `ready` at T+33 with `result` = {32'h12345678, 32'hFFFFFFFF}.
- Annul: `annul` at T+10 -> `busy`=0 at T+11; no `ready` within 40 cycles; `result` equals the prior value. A new `start` at T+12 completes normally at T+45.
- Reset: `rst`=0 at T+5 -> `busy`, `ready`, `result` immediately 0. After release, 100/7 completes at full latency.
- Early-out (macro defined): a=3, b=10 unsigned -> `ready` at T+1 with `result` = {32'd3, 32'd0}. Without the macro, the same result arrives at T+33.

Source files
------------

// File: rtl/hilo_div.sv
// hilo_div: iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU.
// It produces {HI = remainder, LO = quotient} for the HI/LO write path.
//
// Ports:
//   clk         system clock; all state updates on the rising edge
//   rst         asynchronous reset, active low
//   start       begin a divide (sampled only in IDLE)
//   signed_div  1 = DIV (two's complement), 0 = DIVU; sampled with start
//   a, b        dividend / divisor; sampled with start
//   annul       synchronous cancel of an in-flight divide
//   busy        stall request: (IDLE & start) | RUN
//   ready       single-cycle result-valid pulse (DONE state)
//   result      {HI, LO}; holds until the next completed divide
//
// Optional build macro:
//   HILO_DIV_EARLY_OUT_EN  when |a| < |b| and b != 0, go straight from IDLE to
//                          DONE with LO = 0 and HI = a (ready one cycle after start).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring step per cycle, 32 steps (cnt 0..31)
// DONE  | result registered; ready pulses for one cycle
module hilo_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] rq;          // {rem, quo}
  logic [31:0] dmag;
  logic [31:0] a_raw;
  logic        sdiv_q, sa_q, sb_q, bzero_q;

  // operand capture in IDLE
  logic        sa_in, sb_in;
  logic [31:0] amag_in, bmag_in;
  logic        early;

  assign sa_in   = signed_div & a[31];
  assign sb_in   = signed_div & b[31];
  assign amag_in = sa_in ? (32'd0 - a) : a;
  assign bmag_in = sb_in ? (32'd0 - b) : b;

`ifdef HILO_DIV_EARLY_OUT_EN
  assign early = (amag_in < bmag_in) && (b != 32'd0);
`else
  assign early = 1'b0;
`endif

  // one restoring step
  logic [63:0] shifted;
  logic [32:0] diff;
  logic [63:0] rq_step;

  // The bit shifted out of rem[31] is kept as bit 32 of the trial value;
  // without it, divisors >= 2^31 would lose the partial remainder MSB.
  assign shifted = {rq[62:0], 1'b0};
  assign diff    = {rq[63], shifted[63:32]} - {1'b0, dmag};
  assign rq_step = diff[32] ? shifted : {diff[31:0], shifted[31:1], 1'b1};

  // sign correction of the final step
  logic [31:0] q_raw, r_raw, q_fix, r_fix;
  logic [63:0] final_res;

  assign q_raw     = rq_step[31:0];
  assign r_raw     = rq_step[63:32];
  assign q_fix     = (sdiv_q && (sa_q ^ sb_q)) ? (32'd0 - q_raw) : q_raw;
  assign r_fix     = (sdiv_q && sa_q) ? (32'd0 - r_raw) : r_raw;
  assign final_res = bzero_q ? {a_raw, 32'hFFFF_FFFF} : {r_fix, q_fix};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        busy = start;
        if (start) begin
          state_nxt = early ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (annul) begin
          state_nxt = IDLE;
        end else if (cnt == 6'd31) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 6'd0;
      rq      <= 64'd0;
      dmag    <= 32'd0;
      a_raw   <= 32'd0;
      sdiv_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bzero_q <= 1'b0;
      result  <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= 6'd0;
            rq      <= {32'd0, amag_in};
            dmag    <= bmag_in;
            a_raw   <= a;
            sdiv_q  <= signed_div;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            bzero_q <= (b == 32'd0);
            if (early) begin
              // remainder is the dividend itself, already carrying its sign
              result <= {a, 32'd0};
            end
          end
        end
        RUN: begin
          if (!annul) begin
            rq  <= rq_step;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              result <= final_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div.sv
module tb_hilo_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [63:0] result;

  hilo_div dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .busy       (busy),
    .ready      (ready),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sdiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    bit          eo;     // operands qualify for the early-out path
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] last_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issues one divide in the next cycle (T) and follows it to ready
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    int busy_bad;
    int exp_lat;
    bit seen;
`ifdef HILO_DIV_EARLY_OUT_EN
    exp_lat = v.eo ? 1 : 33;
`else
    exp_lat = 33;
`endif
    tick();
    start = 1'b1; signed_div = v.sdiv; a = v.a; b = v.b;
    @(negedge clk);
    chk({name, "_busy_issue"}, {63'd0, busy}, 64'd1);
    tick();
    start = 1'b0; a = 32'd0; b = 32'd0; signed_div = 1'b0;
    lat = 0; busy_bad = 0; seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      if (!busy) busy_bad++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_busy_run"}, 64'(busy_bad), 64'd0);
    if (seen) begin
      chk({name, "_result"}, result, v.exp);
      chk({name, "_busy_done"}, {63'd0, busy}, 64'd0);
      tick();
      @(negedge clk);
      chk({name, "_ready_pulse"}, {63'd0, ready}, 64'd0);
    end
    last_res = v.exp;
  endtask

  // starts 1000/3 unsigned in T, annuls in T+10; returns inside T+11
  task automatic annul_seq(input string name);
    tick();
    start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin start = 1'b0; a = 32'd0; b = 32'd0; end
      if (k == 10) annul = 1'b1;
    end
    tick();
    annul = 1'b0;
    @(negedge clk);
    chk({name, "_busy_after_annul"}, {63'd0, busy}, 64'd0);
    chk({name, "_ready_after_annul"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    int n_rdy;
    int lat;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD},  1'b0};
    vecs[2]  = '{1'b0, 32'h1234_5678,  32'd0,          {32'h1234_5678,  32'hFFFF_FFFF},  1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000},  1'b0};
    vecs[4]  = '{1'b0, 32'd3,          32'd10,         {32'd3,          32'd0},          1'b1};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD},  1'b0};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF,  32'd3},          1'b0};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF},  1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0,          32'd1},          1'b0};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'd0,          {32'hFFFF_FF9C,  32'hFFFF_FFFF},  1'b0};
    vecs[10] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          {32'd1,          32'h7FFF_FFFC},  1'b0};
    vecs[11] = '{1'b1, 32'hFFFF_FFFD,  32'd10,         {32'hFFFF_FFFD,  32'd0},          1'b1};
    vecs[12] = '{1'b0, 32'd0,          32'd5,          {32'd0,          32'd0},          1'b1};
    vecs[13] = '{1'b1, 32'h7FFF_FFFF,  32'h10,         {32'h0000_000F,  32'h07FF_FFFF},  1'b0};
    vecs[14] = '{1'b0, 32'd1000000,    32'd1000,       {32'd0,          32'h0000_03E8},  1'b0};

    rst = 1'b0; start = 1'b0; signed_div = 1'b0; a = 32'd0; b = 32'd0; annul = 1'b0;
    last_res = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",   {63'd0, busy},  64'd0);
    chk("reset_ready",  {63'd0, ready}, 64'd0);
    chk("reset_result", result,         64'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // start held through RUN/DONE with changing operands, annul in IDLE and DONE
    tick();
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7; annul = 1'b1;
    @(negedge clk);
    chk("hold_busy_issue", {63'd0, busy}, 64'd1);
    tick();
    annul = 1'b0; a = 32'd5; b = 32'd1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin
        tick();
        if (k == 33) annul = 1'b1;
      end
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
    end
    chk("hold_latency", 64'(lat), 64'd33);
    chk("hold_result", result, {32'd2, 32'd14});
    chk("hold_busy_done", {63'd0, busy}, 64'd0);
    tick();
    start = 1'b0; annul = 1'b0; a = 32'd0; b = 32'd0;
    @(negedge clk);
    chk("hold_no_restart", {63'd0, busy | ready}, 64'd0);
    chk("hold_result_kept", result, {32'd2, 32'd14});
    last_res = {32'd2, 32'd14};

    // annul, then watch 40 cycles for a stray ready or result change
    annul_seq("annul1");
    n_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      @(negedge clk);
      if (ready) n_rdy++;
    end
    chk("annul1_no_ready", 64'(n_rdy), 64'd0);
    chk("annul1_result_kept", result, last_res);

    // annul, then new start two cycles later completes at full latency
    annul_seq("annul2");
    run_vec(vecs[0], "annul2_restart");

    // reset in the middle of RUN
    tick();
    start = 1'b1; signed_div = 1'b1; a = 32'hFFFF_FFF9; b = 32'd2;
    tick();
    start = 1'b0; a = 32'd0; b = 32'd0; signed_div = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy",   {63'd0, busy},  64'd0);
    chk("midrst_ready",  {63'd0, ready}, 64'd0);
    chk("midrst_result", result,         64'd0);
    last_res = 64'd0;
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
